// File: rtl/fread_ram_loader_pkg.sv
// Shared types for the fread RAM loader: FSM state encoding and the bytes-per-word helper.
package fread_loader_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  function automatic int unsigned bytes_per_word(input int unsigned word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/fread_ram_loader_if.sv
// Request/response link between the RAM loader and the file reader that serves chunk reads.
interface fread_ram_loader_if;
  // A request transfers on a rising clk edge where req_valid && req_ready; req_offset is
  // held stable while req_valid is high. resp_data is taken whenever resp_valid is high;
  // the response stream has no backpressure.
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_offset;
  logic [7:0]  resp_data;
  logic        resp_valid;

  modport master (
    output req_valid, req_offset,
    input  req_ready, resp_data, resp_valid
  );

  modport slave (
    input  req_valid, req_offset,
    output req_ready, resp_data, resp_valid
  );
endinterface

// File: rtl/fread_ram_loader_mem.sv
// Simple dual-port word RAM: one write port, one registered read port (block-RAM style).
module loader_mem #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned DEPTH  = 6144
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0]        rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array contents survive rst.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fread_ram_loader.sv
// Loads a RAM image from a chunked byte-stream file reader, then serves one-cycle reads.
// Define FREAD_LOADER_CSUM_EN to build the 16-bit load checksum; otherwise csum is tied to 0.
module fread_ram_loader
  import fread_loader_pkg::*;
#(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned DEPTH       = 6144,
  parameter int unsigned CHUNK_BYTES = 2048,
  parameter logic [31:0] BASE_OFFSET = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reload,
  fread_ram_loader_if.master       req_if,
  output logic                     loading,
  output logic                     ram_ready,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WORD_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [15:0]              csum,
  output loader_state_e            dbg_state
);
  localparam int unsigned BPW        = bytes_per_word(WORD_W);
  localparam int unsigned TOTAL      = DEPTH * BPW;
  localparam int unsigned CNT_W      = $clog2(TOTAL + 1);
  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned LANE_SH    = $clog2(BPW);
  localparam int unsigned CHUNK_SH   = $clog2(CHUNK_BYTES);
  localparam logic [31:0] CHUNK_MASK = 32'(CHUNK_BYTES - 1);
  localparam logic [31:0] LANE_MASK  = 32'(BPW - 1);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [31:0]       chunk_idx_q;
  logic [WORD_W-1:0] word_q, word_d;
  logic [31:0]       cnt32;
  logic              accept, last_byte, chunk_end, word_done, mem_re;
  logic              rd_valid_q;
  logic [AW-1:0]     wr_addr;

  assign cnt32     = 32'(byte_cnt_q);
  // reload wins over a byte arriving in the same cycle
  assign accept    = (state_q == RECV) && req_if.resp_valid && !reload;
  assign last_byte = (cnt32 == 32'(TOTAL - 1));
  assign chunk_end = (cnt32 & CHUNK_MASK) == CHUNK_MASK;
  assign word_done = (cnt32 & LANE_MASK) == LANE_MASK;
  assign wr_addr   = AW'(cnt32 >> LANE_SH);

  // Little-endian assembly: byte lane is the byte count modulo bytes-per-word.
  always_comb begin
    word_d = word_q;
    for (int unsigned b = 0; b < BPW; b++) begin
      if ((cnt32 & LANE_MASK) == 32'(b)) word_d[8*b +: 8] = req_if.resp_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ:  if (req_if.req_ready) state_d = RECV;
      RECV: begin
        if (accept) begin
          if (last_byte)      state_d = DONE;
          else if (chunk_end) state_d = REQ;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = REQ;
    endcase
    if (reload) state_d = REQ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      byte_cnt_q  <= '0;
      chunk_idx_q <= '0;
      word_q      <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= mem_re;
      if (reload) begin
        byte_cnt_q  <= '0;
        chunk_idx_q <= '0;
        word_q      <= '0;
      end else if (accept) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
        word_q     <= word_d;
        if (chunk_end && !last_byte) chunk_idx_q <= chunk_idx_q + 32'd1;
      end
    end
  end

  assign req_if.req_valid  = (state_q == REQ);
  assign req_if.req_offset = BASE_OFFSET + (chunk_idx_q << CHUNK_SH);
  assign loading           = (state_q != DONE);
  assign ram_ready         = (state_q == DONE);
  assign dbg_state         = state_q;
  assign mem_re            = rd_en && (state_q == DONE) && !reload;
  assign rd_valid          = rd_valid_q;

  loader_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && word_done),
    .waddr (wr_addr),
    .wdata (word_d),
    .re    (mem_re),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef FREAD_LOADER_CSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge clk) begin
    if (rst || reload) csum_q <= '0;
    else if (accept)   csum_q <= csum_q + {8'h00, req_if.resp_data};
  end
  assign csum = csum_q;
`else
  assign csum = 16'h0;
`endif
endmodule

// File: tb/tb_fread_ram_loader.sv
// Bench for fread_ram_loader: a default-parameter instance and a 32-bit/partial-chunk instance.
module tb_fread_ram_loader;
  import fread_loader_pkg::*;

  localparam int unsigned A_DEPTH = 6144, A_CHUNK = 2048, A_T = A_DEPTH * 2;
  localparam logic [31:0] A_BASE  = 32'h0;
  localparam int unsigned B_DEPTH = 1000, B_CHUNK = 1024, B_T = B_DEPTH * 4, B_IMG = 4096;
  localparam logic [31:0] B_BASE  = 32'h100;

  typedef struct {
    int unsigned addr;
    logic [31:0] exp;
  } rd_vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fread_ram_loader_if a_if ();
  fread_ram_loader_if b_if ();
  logic a_reload, a_rd_en, a_rd_valid, a_loading, a_ram_ready;
  logic [12:0] a_rd_addr;
  logic [15:0] a_rd_data, a_csum;
  loader_state_e a_dbg;
  logic b_reload, b_rd_en, b_rd_valid, b_loading, b_ram_ready;
  logic [9:0]  b_rd_addr;
  logic [31:0] b_rd_data;
  logic [15:0] b_csum;
  loader_state_e b_dbg;

  fread_ram_loader dut_a (
    .clk(clk), .rst(rst), .reload(a_reload), .req_if(a_if),
    .loading(a_loading), .ram_ready(a_ram_ready), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .csum(a_csum), .dbg_state(a_dbg)
  );

  fread_ram_loader #(
    .WORD_W(32), .DEPTH(B_DEPTH), .CHUNK_BYTES(B_CHUNK), .BASE_OFFSET(B_BASE)
  ) dut_b (
    .clk(clk), .rst(rst), .reload(b_reload), .req_if(b_if),
    .loading(b_loading), .ram_ready(b_ram_ready), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .csum(b_csum), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int errors = 0;
  int checks = 0;
  logic abort = 1'b0;
  logic [7:0]  img_a [A_T];
  logic [7:0]  img_b [B_IMG];
  logic [31:0] exp_q [$];
  rd_vec_t     vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_word_a(input int unsigned k);
    return {img_a[2*k+1], img_a[2*k]};
  endfunction

  function automatic logic [31:0] model_word_b(input int unsigned k);
    return {img_b[4*k+3], img_b[4*k+2], img_b[4*k+1], img_b[4*k]};
  endfunction

  function automatic logic [15:0] model_csum_a();
    logic [15:0] s = 16'h0;
`ifdef FREAD_LOADER_CSUM_EN
    for (int unsigned k = 0; k < A_T; k++) s = s + 16'(img_a[k]);
`endif
    return s;
  endfunction

  function automatic logic [15:0] model_csum_b();
    logic [15:0] s = 16'h0;
`ifdef FREAD_LOADER_CSUM_EN
    for (int unsigned k = 0; k < B_T; k++) s = s + 16'(img_b[k]);
`endif
    return s;
  endfunction

  task automatic plan_offsets(input logic [31:0] base, input int unsigned chunk, input int unsigned total);
    exp_q.delete();
    for (int unsigned off = 0; off < total; off += chunk) exp_q.push_back(base + off);
  endtask

  // ---------------- drivers ----------------
  task automatic serve_a(input int stall, input int reload_at);
    int sent;
    int unsigned chunk, i, wait_cyc;
    logic [31:0] off0;
    logic bad_rdv;
    sent = 0;
    chunk = 0;
    while (sent < int'(A_T) && !abort) begin
      a_if.req_ready = 1'b0;
      wait_cyc = 0;
      while (a_if.req_valid !== 1'b1 && wait_cyc < 200) begin tick(); wait_cyc++; end
      if (a_if.req_valid !== 1'b1) begin check("a_req_timeout", 0, 1); abort = 1'b1; return; end
      if (exp_q.size() == 0) begin check("a_req_extra", 1, 0); abort = 1'b1; return; end
      check("a_req_offset", a_if.req_offset, exp_q.pop_front());
      off0 = a_if.req_offset;
      if (chunk == 0 && stall > 0) begin
        for (int c = 0; c < stall; c++) begin
          a_if.resp_valid = 1'b1;
          a_if.resp_data  = 8'hEE;
          a_rd_en         = 1'b1;
          a_rd_addr       = 13'(c);
          tick();
          check("a_stall_req_valid", a_if.req_valid, 1);
          check("a_stall_offset", a_if.req_offset, off0);
          check("a_stall_rd_valid", a_rd_valid, 0);
        end
        a_if.resp_valid = 1'b0;
        a_rd_en         = 1'b0;
      end else begin
        repeat ($urandom_range(0, 2)) tick();
      end
      a_if.req_ready = 1'b1;
      tick();
      a_if.req_ready = 1'b0;
      i = 0;
      bad_rdv = 1'b0;
      while (i < A_CHUNK && sent < int'(A_T)) begin
        a_rd_en   = ($urandom_range(0, 3) == 0);
        a_rd_addr = 13'($urandom_range(0, A_DEPTH - 1));
        if ($urandom_range(0, 7) == 0) begin
          a_if.resp_valid = 1'b0;
          tick();
        end else begin
          a_if.resp_valid = 1'b1;
          a_if.resp_data  = img_a[chunk*A_CHUNK + i];
          if (sent == reload_at) begin
            a_reload = 1'b1;
            tick();
            a_reload = 1'b0;
            a_if.resp_valid = 1'b0;
            a_rd_en = 1'b0;
            check("a_reload_req_valid", a_if.req_valid, 1);
            check("a_reload_offset", a_if.req_offset, A_BASE);
            check("a_reload_loading", a_loading, 1);
            check("a_reload_ram_ready", a_ram_ready, 0);
            return;
          end
          tick();
          i++;
          sent++;
        end
        if (a_rd_valid !== 1'b0) bad_rdv = 1'b1;
      end
      a_if.resp_valid = 1'b0;
      a_rd_en = 1'b0;
      check("a_rd_valid_during_load", bad_rdv, 0);
      chunk++;
    end
    if (!abort) check("a_offsets_consumed", exp_q.size(), 0);
  endtask

  task automatic serve_b();
    int unsigned i, idx, wait_cyc;
    for (int unsigned chunk = 0; chunk < (B_T + B_CHUNK - 1) / B_CHUNK && !abort; chunk++) begin
      b_if.req_ready = 1'b0;
      wait_cyc = 0;
      while (b_if.req_valid !== 1'b1 && wait_cyc < 200) begin tick(); wait_cyc++; end
      if (b_if.req_valid !== 1'b1) begin check("b_req_timeout", 0, 1); abort = 1'b1; return; end
      if (exp_q.size() == 0) begin check("b_req_extra", 1, 0); abort = 1'b1; return; end
      check("b_req_offset", b_if.req_offset, exp_q.pop_front());
      repeat ($urandom_range(0, 3)) tick();
      b_if.req_ready = 1'b1;
      tick();
      b_if.req_ready = 1'b0;
      i = 0;
      // The server always sends a full chunk; bytes past the image end are excess.
      while (i < B_CHUNK) begin
        if ($urandom_range(0, 5) == 0) begin
          b_if.resp_valid = 1'b0;
          tick();
        end else begin
          idx = chunk*B_CHUNK + i;
          b_if.resp_valid = 1'b1;
          b_if.resp_data  = img_b[idx];
          tick();
          i++;
          if (idx == B_T - 2) check("b_not_ready_early", b_ram_ready, 0);
          if (idx == B_T - 1) check("b_ready_at_last_byte", b_ram_ready, 1);
        end
      end
      b_if.resp_valid = 1'b0;
    end
    if (!abort) check("b_offsets_consumed", exp_q.size(), 0);
  endtask

  task automatic read_b2b_a();
    a_rd_en = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      a_rd_addr = 13'(k);
      tick();
      check("a_b2b_rd_valid", a_rd_valid, 1);
      check("a_b2b_rd_data", a_rd_data, model_word_a(k));
    end
    a_rd_en = 1'b0;
    tick();
    check("a_b2b_idle_rd_valid", a_rd_valid, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    a_reload = 1'b0; a_rd_en = 1'b0; a_rd_addr = '0;
    a_if.req_ready = 1'b0; a_if.resp_valid = 1'b0; a_if.resp_data = '0;
    b_reload = 1'b0; b_rd_en = 1'b0; b_rd_addr = '0;
    b_if.req_ready = 1'b0; b_if.resp_valid = 1'b0; b_if.resp_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("a_rst_req_valid", a_if.req_valid, 1);
    check("a_rst_offset", a_if.req_offset, A_BASE);
    check("a_rst_loading", a_loading, 1);
    check("a_rst_ram_ready", a_ram_ready, 0);
    check("a_rst_rd_valid", a_rd_valid, 0);
    check("a_rst_rd_data", a_rd_data, 0);
    check("a_rst_csum", a_csum, 0);
    check("a_rst_state", 64'(a_dbg), 64'(REQ));
    check("b_rst_req_valid", b_if.req_valid, 1);
    check("b_rst_offset", b_if.req_offset, B_BASE);
    check("b_rst_rd_data", b_rd_data, 0);

    // Load 1: all-0x01 image with a 50-cycle request stall up front.
    for (int unsigned k = 0; k < A_T; k++) img_a[k] = 8'h01;
    plan_offsets(A_BASE, A_CHUNK, A_T);
    serve_a(50, -1);
    check("a_load1_ram_ready", a_ram_ready, 1);
    check("a_load1_loading", a_loading, 0);
    check("a_load1_req_valid", a_if.req_valid, 0);
    check("a_load1_csum", a_csum, model_csum_a());

    // Reload from DONE, then abort a load with reload on byte 3000, then load fully.
    a_reload = 1'b1;
    tick();
    a_reload = 1'b0;
    check("a_reload_done_ram_ready", a_ram_ready, 0);
    check("a_reload_done_req_valid", a_if.req_valid, 1);
    for (int unsigned k = 0; k < A_T; k++) img_a[k] = 8'($urandom);
    plan_offsets(A_BASE, A_CHUNK, A_T);
    serve_a(0, 3000);
    for (int unsigned k = 0; k < A_T; k++) img_a[k] = 8'($urandom);
    plan_offsets(A_BASE, A_CHUNK, A_T);
    serve_a(0, -1);
    check("a_load2_ram_ready", a_ram_ready, 1);
    check("a_load2_csum", a_csum, model_csum_a());
    read_b2b_a();

    vecs[0].addr = 5;    vecs[1].addr = 0;    vecs[2].addr = 1023; vecs[3].addr = 1024;
    vecs[4].addr = 2047; vecs[5].addr = 6143;
    vecs[6].addr = $urandom_range(0, A_DEPTH - 1);
    vecs[7].addr = $urandom_range(0, A_DEPTH - 1);
    for (int v = 0; v < 8; v++) vecs[v].exp = 32'(model_word_a(vecs[v].addr));
    for (int v = 0; v < 8; v++) begin
      a_rd_en = 1'b1;
      a_rd_addr = 13'(vecs[v].addr);
      tick();
      a_rd_en = 1'b0;
      check("a_vec_rd_valid", a_rd_valid, 1);
      check("a_vec_rd_data", a_rd_data, vecs[v].exp[15:0]);
      tick();
      check("a_vec_idle_rd_valid", a_rd_valid, 0);
    end

    // Instance B: 32-bit words, partial final chunk, excess bytes after the image end.
    for (int unsigned k = 0; k < B_IMG; k++) img_b[k] = 8'($urandom);
    plan_offsets(B_BASE, B_CHUNK, B_T);
    serve_b();
    check("b_ram_ready", b_ram_ready, 1);
    check("b_loading", b_loading, 0);
    check("b_req_valid", b_if.req_valid, 0);
    check("b_csum", b_csum, model_csum_b());
    vecs[0].addr = 0;   vecs[1].addr = 1;   vecs[2].addr = 2;   vecs[3].addr = 767;
    vecs[4].addr = 768; vecs[5].addr = 999;
    vecs[6].addr = $urandom_range(0, B_DEPTH - 1);
    vecs[7].addr = $urandom_range(0, B_DEPTH - 1);
    for (int v = 0; v < 8; v++) vecs[v].exp = model_word_b(vecs[v].addr);
    b_rd_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      b_rd_addr = 10'(vecs[v].addr);
      tick();
      check("b_vec_rd_valid", b_rd_valid, 1);
      check("b_vec_rd_data", b_rd_data, vecs[v].exp);
    end
    b_rd_en = 1'b0;
    tick();
    check("b_idle_rd_valid", b_rd_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/fread_ram_loader.md
FREAD_RAM_LOADER -- requirements
Module: fread_ram_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 16, RAM word width in bits; legal values 8, 16, 32.
REQ-002 SHALL have parameter DEPTH, default 6144, RAM depth in words.
REQ-003 SHALL have parameter CHUNK_BYTES, default 2048, bytes per fread request; power of two.
REQ-004 SHALL have parameter BASE_OFFSET, default 32'h0, file offset of the first byte.
REQ-005 SHALL have clock clk: input, 1 bit, rising-edge clock for all state.
REQ-006 SHALL have reset rst: input, 1 bit, synchronous, active-high.
REQ-007 SHALL have reload: input, 1 bit, restarts the full load from chunk 0.
REQ-008 SHALL have req_valid: output, 1 bit, fread request pending.
REQ-009 SHALL have req_ready: input, 1 bit, request accepted when high with req_valid.
REQ-010 SHALL have req_offset: output, 32 bits, file byte offset of the requested chunk.
REQ-011 SHALL have resp_data: input, 8 bits, response byte.
REQ-012 SHALL have resp_valid: input, 1 bit, resp_data valid this cycle; no backpressure.
REQ-013 SHALL have loading: output, 1 bit, high while the load is in progress.
REQ-014 SHALL have ram_ready: output, 1 bit, high when all DEPTH words are loaded.
REQ-015 SHALL have rd_en: input, 1 bit, read strobe.
REQ-016 SHALL have rd_addr: input, $clog2(DEPTH) bits, read word address.
REQ-017 SHALL have rd_data: output, WORD_W bits, read data.
REQ-018 SHALL have rd_valid: output, 1 bit, rd_data valid.
REQ-019 SHALL have csum: output, 16 bits, load checksum.

Function
REQ-020 SHALL implement the states REQ, RECV and DONE, and SHALL enter REQ on rst.
- REQ: req_valid=1; on req_valid&req_ready go to RECV.
- RECV: transition to REQ after the CHUNK_BYTES-th byte of the chunk; transition to DONE after the last byte of the total.
REQ-021 SHALL drive req_offset = BASE_OFFSET + chunk_idx*CHUNK_BYTES, computed modulo 2^32, held stable while req_valid=1.
REQ-022 SHALL define total bytes T = DEPTH*WORD_W/8; the final chunk MAY be partial, with RECV ending after byte T.
REQ-023 SHALL ignore resp_valid bytes outside RECV and bytes beyond T.
REQ-024 SHALL assemble bytes little-endian, first byte in bits [7:0], and SHALL write each word to address byte_cnt/(WORD_W/8) in the cycle its last byte arrives.
REQ-025 SHALL assert loading in REQ and RECV, and SHALL assert ram_ready only in DONE; the two SHALL be mutually exclusive.
REQ-026 SHALL, in DONE, on rd_en, drive rd_data = mem[rd_addr] with rd_valid=1 on the next cycle (one-cycle latency); rd_valid SHALL be 0 otherwise.
REQ-027 SHALL ignore rd_en while loading, keeping rd_valid=0.
REQ-028 SHALL, on reload in any state: clear chunk_idx and byte_cnt, go to REQ next cycle and drop ram_ready next cycle; an outstanding request SHALL be abandoned.
REQ-029 SHALL give reload precedence over a simultaneous resp_valid byte or req_ready.
REQ-030 SHALL give rst precedence over reload.

Reset
REQ-031 SHALL set on rst: req_valid=1 on the cycle after reset, chunk_idx=0, byte_cnt=0, loading=1, ram_ready=0, rd_valid=0, rd_data=0, csum=0.
REQ-032 SHALL leave RAM contents unaffected by rst.

Configuration
REQ-033 SHALL, with FREAD_LOADER_CSUM_EN defined, drive csum as the 16-bit wrapping sum of all T accepted bytes, cleared on rst/reload and final once ram_ready=1.
REQ-034 SHALL, without FREAD_LOADER_CSUM_EN, keep the csum port and tie it to 16'h0, with no adder logic.

Structure
REQ-035 SHALL place the state enum (REQ, RECV, DONE) and the bytes-per-word constant helper in package fread_loader_pkg.
REQ-036 SHALL place the RAM array in sub-module loader_mem: one write port, one registered read port, inferable as BRAM/SPRAM.

Verification
REQ-037 SHALL cover default parameters with a model serving 2048-byte chunks: offsets 0x0, 0x800 ... 0x2800 requested; ram_ready after 12288 bytes; rd_addr=5 returns {byte11,byte10}.
REQ-038 SHALL cover WORD_W=32, DEPTH=1000, CHUNK_BYTES=1024, BASE_OFFSET=0x100: 4 requests at 0x100, 0x500, 0x900, 0xD00; the last chunk stops after 928 bytes; excess bytes ignored.
REQ-039 SHALL cover req_ready held low for 50 cycles: req_valid and req_offset stay stable; no bytes written.
REQ-040 SHALL cover reload asserted at byte 3000 together with resp_valid: that byte is dropped; next request offset 0x0; full reload completes with correct data.
REQ-041 SHALL cover rd_en during load: rd_valid=0; in DONE, back-to-back rd_en to addresses 0,1,2 gives three consecutive rd_valid cycles with matching data.
REQ-042 SHALL cover FREAD_LOADER_CSUM_EN defined with all bytes 0x01 at default parameters: csum=0x3000 at ram_ready; without the macro, csum=0.
